// File: rtl/router_pkg.sv
// Shared definitions for the packet router control path.
//   router_state_e : FSM state encoding used by router_fsm_nport
//   NUM_PORTS_MIN/MAX : legal range of the destination FIFO count
//   addr_width()   : header address field width for a given port count
package router_pkg;

    localparam int unsigned NUM_PORTS_MIN = 2;
    localparam int unsigned NUM_PORTS_MAX = 8;

    typedef enum logic [3:0] {
        StDecodeAddr,
        StLoadFirst,
        StLoadData,
        StLoadParity,
        StFifoFull,
        StLoadAfterFull,
        StCheckParity,
        StWaitEmpty,
        StDrop
    } router_state_e;

    // At least one address bit, even for two ports.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fsm_nport.sv
// Router control FSM for NUM_PORTS destination FIFOs.
// Decodes the packet header, steers the write enables through the payload,
// FIFO-full and parity phases, and drops packets addressed to absent ports.
// Ports:
//   clock, resetn        : clock, asynchronous active-low reset
//   pkt_valid            : source packet valid
//   data_in              : header address field (sampled only in decode)
//   parity_done          : parity byte captured
//   low_pkt_valid        : pkt_valid fell while the FIFO was full
//   fifo_full            : full flag of the selected FIFO
//   fifo_empty           : per-port empty flags
//   soft_reset           : per-port timeout soft resets
//   busy, detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, drop_state : state decodes
//   sel_port             : latched destination port
module router_fsm_nport
    import router_pkg::*;
#(
    parameter int unsigned  NUM_PORTS = 3,
    localparam int unsigned ADDR_W    = addr_width(NUM_PORTS)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic [ADDR_W-1:0]    sel_port
);

    if (NUM_PORTS < NUM_PORTS_MIN || NUM_PORTS > NUM_PORTS_MAX) begin : g_num_ports_check
        $error("router_fsm_nport: NUM_PORTS out of range");
    end

    localparam int unsigned    SEL_SPAN   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    router_state_e     state_q, state_d;
    logic [ADDR_W-1:0] sel_q, sel_d;

    // Flags padded to the full address span so any address indexes safely;
    // padding bits read as 0 (not empty, no soft reset).
    logic [SEL_SPAN-1:0] empty_ext;
    logic [SEL_SPAN-1:0] soft_ext;
    logic                addr_ok;
    logic                soft_hit;

    always_comb begin
        empty_ext                  = '0;
        empty_ext[NUM_PORTS-1:0]   = fifo_empty;
        soft_ext                   = '0;
        soft_ext[NUM_PORTS-1:0]    = soft_reset;
    end

    assign addr_ok  = {1'b0, data_in} < PORT_LIMIT;
    assign soft_hit = soft_ext[sel_q];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StDecodeAddr: begin
                if (pkt_valid) begin
                    sel_d = data_in;
                    if (!addr_ok) begin
                        state_d = StDrop;
                    end else if (empty_ext[data_in]) begin
                        state_d = StLoadFirst;
                    end else begin
                        state_d = StWaitEmpty;
                    end
                end
            end
            StLoadFirst:  state_d = StLoadData;
            StLoadData: begin
                if (fifo_full) begin
                    state_d = StFifoFull;
                end else if (!pkt_valid) begin
                    state_d = StLoadParity;
                end
            end
            StFifoFull: begin
                if (!fifo_full) begin
                    state_d = StLoadAfterFull;
                end
            end
            StLoadAfterFull: begin
                if (parity_done) begin
                    state_d = StDecodeAddr;
                end else if (low_pkt_valid) begin
                    state_d = StLoadParity;
                end else begin
                    state_d = StLoadData;
                end
            end
            StLoadParity: state_d = StCheckParity;
            StCheckParity: state_d = fifo_full ? StFifoFull : StDecodeAddr;
            StWaitEmpty: begin
                if (empty_ext[sel_q]) begin
                    state_d = StLoadFirst;
                end
            end
            StDrop: begin
                if (!pkt_valid) begin
                    state_d = StDecodeAddr;
                end
            end
            default: state_d = StDecodeAddr;
        endcase

        // Timeout on the selected port abandons the packet from any active state.
        if (state_q != StDecodeAddr && soft_hit) begin
            state_d = StDecodeAddr;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StDecodeAddr;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Moore output decodes
    always_comb begin
        detect_add    = (state_q == StDecodeAddr);
        lfd_state     = (state_q == StLoadFirst);
        ld_state      = (state_q == StLoadData);
        laf_state     = (state_q == StLoadAfterFull);
        full_state    = (state_q == StFifoFull);
        rst_int_reg   = (state_q == StCheckParity);
        drop_state    = (state_q == StDrop);
        write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity)
                     || (state_q == StLoadAfterFull);
        busy          = (state_q == StLoadFirst) || (state_q == StLoadParity)
                     || (state_q == StFifoFull) || (state_q == StLoadAfterFull)
                     || (state_q == StCheckParity) || (state_q == StWaitEmpty);
    end

    assign sel_port = sel_q;

endmodule

// File: tb/tb_router_fsm_nport.sv
module tb_router_fsm_nport;

    // Phase codes used only by the bench model
    localparam int P_DA = 0, P_LFD = 1, P_LD = 2, P_LP = 3, P_FFS = 4;
    localparam int P_LAF = 5, P_CPE = 6, P_WTE = 7, P_DROP = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 3-port DUT signals
    logic       resetn, pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [1:0] data_in;
    logic [2:0] fifo_empty, soft_reset;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, drop_state;
    logic [1:0] sel_port;

    // 8-port DUT signals
    logic       e_resetn, e_pkt_valid, e_parity_done, e_low_pkt_valid, e_fifo_full;
    logic [2:0] e_data_in;
    logic [7:0] e_fifo_empty, e_soft_reset;
    logic       e_busy, e_detect_add, e_lfd_state, e_ld_state, e_laf_state, e_full_state;
    logic       e_write_enb_reg, e_rst_int_reg, e_drop_state;
    logic [2:0] e_sel_port;

    router_fsm_nport #(.NUM_PORTS(3)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .busy(busy),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .drop_state(drop_state), .sel_port(sel_port)
    );

    router_fsm_nport #(.NUM_PORTS(8)) dut8 (
        .clock(clock), .resetn(e_resetn), .pkt_valid(e_pkt_valid), .data_in(e_data_in),
        .parity_done(e_parity_done), .low_pkt_valid(e_low_pkt_valid),
        .fifo_full(e_fifo_full), .fifo_empty(e_fifo_empty), .soft_reset(e_soft_reset),
        .busy(e_busy), .detect_add(e_detect_add), .lfd_state(e_lfd_state),
        .ld_state(e_ld_state), .laf_state(e_laf_state), .full_state(e_full_state),
        .write_enb_reg(e_write_enb_reg), .rst_int_reg(e_rst_int_reg),
        .drop_state(e_drop_state), .sel_port(e_sel_port)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 3-port DUT ----------------
    int m_ph, m_sel;

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop}
    function automatic logic [8:0] flags(input int ph);
        case (ph)
            P_DA:    return 9'b0_1000_0000;
            P_LFD:   return 9'b1_0100_0000;
            P_LD:    return 9'b0_0010_0100;
            P_LP:    return 9'b1_0000_0100;
            P_FFS:   return 9'b1_0000_1000;
            P_LAF:   return 9'b1_0001_0100;
            P_CPE:   return 9'b1_0000_0010;
            P_WTE:   return 9'b1_0000_0000;
            default: return 9'b0_0000_0001;
        endcase
    endfunction

    function automatic int model_next();
        if (m_ph != P_DA && m_sel < 3 && soft_reset[m_sel]) return P_DA;
        case (m_ph)
            P_DA: begin
                if (!pkt_valid) return P_DA;
                if (data_in >= 2'd3) return P_DROP;
                return fifo_empty[data_in] ? P_LFD : P_WTE;
            end
            P_LFD:  return P_LD;
            P_LD:   return fifo_full ? P_FFS : (pkt_valid ? P_LD : P_LP);
            P_FFS:  return fifo_full ? P_FFS : P_LAF;
            P_LAF:  return parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
            P_LP:   return P_CPE;
            P_CPE:  return fifo_full ? P_FFS : P_DA;
            P_WTE:  return fifo_empty[m_sel] ? P_LFD : P_WTE;
            default: return pkt_valid ? P_DROP : P_DA;
        endcase
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_ph  <= P_DA;
            m_sel <= 0;
        end else begin
            m_ph <= model_next();
            if (m_ph == P_DA && pkt_valid) m_sel <= int'(data_in);
        end
    end

    always @(negedge clock) begin
        if (run_cmp && resetn === 1'b1) begin
            logic [10:0] got, exp;
            got = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, drop_state, sel_port};
            exp = {flags(m_ph), 2'(m_sel)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got %b, expected %b", $time, got, exp);
            end
        end
    end

    // Phase recovered from the DUT's output flags
    function automatic int dut_phase();
        if (detect_add)    return P_DA;
        if (lfd_state)     return P_LFD;
        if (ld_state)      return P_LD;
        if (laf_state)     return P_LAF;
        if (full_state)    return P_FFS;
        if (rst_int_reg)   return P_CPE;
        if (drop_state)    return P_DROP;
        if (write_enb_reg) return P_LP;
        if (busy)          return P_WTE;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_chk(input string name, input int exp);
        tick();
        check(name, dut_phase(), exp);
        check({name, "_model"}, m_ph, exp);
    endtask

    initial begin
        resetn = 1'b1; e_resetn = 1'b1;
        pkt_valid = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
        data_in = '0; fifo_empty = 3'b111; soft_reset = '0;
        e_pkt_valid = 0; e_parity_done = 0; e_low_pkt_valid = 0; e_fifo_full = 0;
        e_data_in = '0; e_fifo_empty = 8'hFF; e_soft_reset = '0;
        #2;
        resetn = 1'b0; e_resetn = 1'b0;
        #1;
        check("reset_flags", int'({busy, detect_add, lfd_state, ld_state, laf_state,
              full_state, write_enb_reg, rst_int_reg, drop_state}), int'(9'b0_1000_0000));
        check("reset_sel", int'(sel_port), 0);
        @(negedge clock);
        resetn = 1'b1; e_resetn = 1'b1;
        run_cmp = 1'b1;

        // Normal packet to port 1: three LD cycles then parity
        pkt_valid = 1; data_in = 2'd1;
        check("p1_da", dut_phase(), P_DA);
        tick_chk("p1_lfd", P_LFD);
        tick_chk("p1_ld1", P_LD);
        tick_chk("p1_ld2", P_LD);
        tick_chk("p1_ld3", P_LD);
        pkt_valid = 0;
        tick_chk("p1_lp", P_LP);
        tick_chk("p1_cpe", P_CPE);
        tick_chk("p1_da_end", P_DA);
        check("p1_sel", int'(sel_port), 1);

        // Out-of-range address: dropped for four cycles
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick_chk("drop", P_DROP);
            check("drop_wen", int'(write_enb_reg), 0);
            check("drop_busy", int'(busy), 0);
        end
        pkt_valid = 0;
        tick_chk("drop_exit", P_DA);

        // Destination not empty: wait, then load
        pkt_valid = 1; data_in = 2'd2; fifo_empty = 3'b011;
        for (int i = 0; i < 5; i++) begin
            tick_chk("wte", P_WTE);
            check("wte_busy", int'(busy), 1);
        end
        fifo_empty = 3'b111;
        tick_chk("wte_lfd", P_LFD);
        tick_chk("wte_ld", P_LD);

        // FIFO full for two cycles, then low_pkt_valid into parity
        fifo_full = 1;
        tick_chk("ffs1", P_FFS);
        tick_chk("ffs2", P_FFS);
        fifo_full = 0; low_pkt_valid = 1; parity_done = 0;
        tick_chk("laf", P_LAF);
        pkt_valid = 0;
        tick_chk("laf_lp", P_LP);
        low_pkt_valid = 0;
        tick_chk("laf_cpe", P_CPE);
        tick_chk("laf_da", P_DA);

        // LAF with parity_done returns to DA; CPE with full goes to FFS
        pkt_valid = 1; data_in = 2'd0;
        tick_chk("b_lfd", P_LFD);
        tick_chk("b_ld", P_LD);
        fifo_full = 1;
        tick_chk("b_ffs", P_FFS);
        fifo_full = 0; parity_done = 1;
        tick_chk("b_laf", P_LAF);
        pkt_valid = 0;
        tick_chk("b_pd_da", P_DA);
        parity_done = 0; pkt_valid = 1;
        tick_chk("c_lfd", P_LFD);
        tick_chk("c_ld", P_LD);
        pkt_valid = 0;
        tick_chk("c_lp", P_LP);
        fifo_full = 1;
        tick_chk("c_cpe", P_CPE);
        tick_chk("c_ffs", P_FFS);
        fifo_full = 0;
        tick_chk("c_laf", P_LAF);
        parity_done = 1;
        tick_chk("c_da", P_DA);
        parity_done = 0;

        // Soft reset: only the selected port counts
        pkt_valid = 1; data_in = 2'd1;
        tick_chk("s_lfd", P_LFD);
        tick_chk("s_ld", P_LD);
        soft_reset = 3'b100;
        tick_chk("s_other", P_LD);
        soft_reset = 3'b010;
        tick_chk("s_sel", P_DA);
        soft_reset = 3'b000; pkt_valid = 0;

        // Asynchronous reset mid-packet on the 3-port DUT
        pkt_valid = 1; data_in = 2'd2;
        tick_chk("r_lfd", P_LFD);
        tick_chk("r_ld", P_LD);
        #2 resetn = 1'b0;
        #1;
        check("r_async_da", int'(detect_add), 1);
        check("r_async_sel", int'(sel_port), 0);
        resetn = 1'b1; pkt_valid = 0;
        tick_chk("r_after", P_DA);

        // 8-port DUT: reset pulse in LAF, between clock edges
        e_pkt_valid = 1; e_data_in = 3'd5;
        tick();
        check("e_lfd", int'(e_lfd_state), 1);
        tick();
        check("e_ld", int'(e_ld_state), 1);
        e_fifo_full = 1;
        tick();
        check("e_ffs", int'(e_full_state), 1);
        e_fifo_full = 0;
        tick();
        check("e_laf", int'(e_laf_state), 1);
        check("e_sel5", int'(e_sel_port), 5);
        #2 e_resetn = 1'b0;
        #1;
        check("e_rst_da", int'(e_detect_add), 1);
        check("e_rst_laf", int'(e_laf_state), 0);
        check("e_rst_busy", int'(e_busy), 0);
        check("e_rst_sel", int'(e_sel_port), 0);
        @(negedge clock);
        e_resetn = 1'b1;
        tick();
        check("e_post_lfd", int'(e_lfd_state), 1);
        check("e_post_sel", int'(e_sel_port), 5);
        e_pkt_valid = 0;

        @(negedge clock);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
